// File: rtl/stage4ma_pkg.sv
// -----------------------------------------------------------------------------
// stage4ma_pkg
//   Shared constants for the memory-access stage:
//   - memory opcodes (instr[23:16], set+opcode byte)
//   - flag bit positions inside the 4-bit flags word
//   - MA stage state encodings
//   - helper that builds the flags word for a completed load
// -----------------------------------------------------------------------------
package stage4ma_pkg;

   localparam int unsigned DATA_W = 24;

   // Memory opcodes (set+opcode byte of the instruction word)
   localparam logic [7:0] OPC_R_LD  = 8'h14;
   localparam logic [7:0] OPC_R_ST  = 8'h15;
   localparam logic [7:0] OPC_I_LDi = 8'h54;
   localparam logic [7:0] OPC_I_STi = 8'h55;

   // Flag bit positions
   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_V = 3;

   typedef enum logic [0:0] {
      MA_S_IDLE = 1'b0,
      MA_S_WAIT = 1'b1
   } ma_state_e;

   // Loads report Z/N of the loaded word; C and V are always cleared.
   function automatic logic [3:0] load_flags(input logic [DATA_W-1:0] data);
      logic [3:0] f;
      f         = 4'b0000;
      f[FLAG_Z] = (data == '0);
      f[FLAG_N] = data[DATA_W-1];
      return f;
   endfunction

endpackage

// File: rtl/stage4ma_decode.sv
// -----------------------------------------------------------------------------
// stage4ma_decode
//   Combinational memory-op decode of the set+opcode byte. Kept separate so
//   hazard logic can reuse the same classification.
// Ports:
//   opc_in  in  8  instr[23:16]
//   is_ld   out 1  load opcode
//   is_st   out 1  store opcode
//   is_mem  out 1  load or store
// -----------------------------------------------------------------------------
module stage4ma_decode
   import stage4ma_pkg::*;
(
   input  logic [7:0] opc_in,
   output logic       is_ld,
   output logic       is_st,
   output logic       is_mem
);

   assign is_ld  = (opc_in == OPC_R_LD) || (opc_in == OPC_I_LDi);
   assign is_st  = (opc_in == OPC_R_ST) || (opc_in == OPC_I_STi);
   assign is_mem = is_ld | is_st;

endmodule

// File: rtl/stage4ma.sv
// -----------------------------------------------------------------------------
// stage4ma
//   Memory-access pipeline stage between the EX/MA latch and write-back.
//   Non-memory instructions pass through in one cycle. Loads/stores issue a
//   single-beat request on the data-memory port, stall upstream until
//   mem_ready (or timeout), then retire into the MA/WB latch.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   MA_S_IDLE | no request outstanding; accepts enable_in every cycle
//   MA_S_WAIT | request outstanding; stall_out high, waiting for mem_ready
//
// Ports:
//   clk, rst_n              clock / async active-low reset
//   enable_in, pc_in, instr_in, tgt_gp_in, tgt_sr_in, result_in, flags_in,
//   store_data_in, branch_taken_in        EX/MA latch contents
//   stall_out               upstream hold (combinational, state==MA_S_WAIT)
//   mem_req/we/addr/wdata   data-memory request (registered)
//   mem_ready, mem_rdata    data-memory response
//   enable_out .. branch_taken_out        MA/WB latch
//   fault_out               sticky memory-timeout fault
// Parameters:
//   TIMEOUT_CYCLES  wait cycles before abort (0 = never); must be < 2**CNT_W
//   CNT_W           wait counter width
// -----------------------------------------------------------------------------
module stage4ma
   import stage4ma_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable_in,
   input  logic [23:0] pc_in,
   input  logic [23:0] instr_in,
   input  logic [3:0]  tgt_gp_in,
   input  logic [3:0]  tgt_sr_in,
   input  logic [23:0] result_in,
   input  logic [3:0]  flags_in,
   input  logic [23:0] store_data_in,
   input  logic        branch_taken_in,
   output logic        stall_out,
   output logic        mem_req,
   output logic        mem_we,
   output logic [23:0] mem_addr,
   output logic [23:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [23:0] mem_rdata,
   output logic        enable_out,
   output logic [23:0] pc_out,
   output logic [23:0] instr_out,
   output logic [3:0]  tgt_gp_out,
   output logic [3:0]  tgt_sr_out,
   output logic [23:0] result_out,
   output logic [3:0]  flags_out,
   output logic        branch_taken_out,
   output logic        fault_out
);

   localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   // The counter holds the number of wait cycles already spent without
   // mem_ready, so the abort fires on the cycle it would reach TIMEOUT_CYCLES:
   // mem_req is then high for exactly TIMEOUT_CYCLES cycles.
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

   logic is_ld, is_st, is_mem;

   stage4ma_decode u_decode (
      .opc_in (instr_in[23:16]),
      .is_ld  (is_ld),
      .is_st  (is_st),
      .is_mem (is_mem)
   );

   ma_state_e   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic        mem_req_q,   mem_req_d;
   logic        mem_we_q,    mem_we_d;
   logic [23:0] mem_addr_q,  mem_addr_d;
   logic [23:0] mem_wdata_q, mem_wdata_d;

   // Holding registers for the instruction in flight
   logic [23:0] hold_pc_q,    hold_pc_d;
   logic [23:0] hold_instr_q, hold_instr_d;
   logic [3:0]  hold_gp_q,    hold_gp_d;
   logic [3:0]  hold_sr_q,    hold_sr_d;
   logic [3:0]  hold_flags_q, hold_flags_d;
   logic        hold_bt_q,    hold_bt_d;

   // MA/WB latch
   logic        en_q,     en_d;
   logic [23:0] pc_q,     pc_d;
   logic [23:0] instr_q,  instr_d;
   logic [3:0]  gp_q,     gp_d;
   logic [3:0]  sr_q,     sr_d;
   logic [23:0] result_q, result_d;
   logic [3:0]  flags_q,  flags_d;
   logic        bt_q,     bt_d;
   logic        fault_q,  fault_d;

   logic        timeout_hit;

   assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      hold_pc_d    = hold_pc_q;
      hold_instr_d = hold_instr_q;
      hold_gp_d    = hold_gp_q;
      hold_sr_d    = hold_sr_q;
      hold_flags_d = hold_flags_q;
      hold_bt_d    = hold_bt_q;
      en_d         = 1'b0;
      pc_d         = pc_q;
      instr_d      = instr_q;
      gp_d         = gp_q;
      sr_d         = sr_q;
      result_d     = result_q;
      flags_d      = flags_q;
      bt_d         = bt_q;
      fault_d      = fault_q;

      case (state_q)
         MA_S_IDLE: begin
            if (enable_in) begin
               if (is_mem) begin
                  state_d      = MA_S_WAIT;
                  cnt_d        = '0;
                  mem_req_d    = 1'b1;
                  mem_we_d     = is_st;
                  mem_addr_d   = result_in;
                  mem_wdata_d  = is_st ? store_data_in : 24'd0;
                  hold_pc_d    = pc_in;
                  hold_instr_d = instr_in;
                  hold_gp_d    = tgt_gp_in;
                  hold_sr_d    = tgt_sr_in;
                  hold_flags_d = flags_in;
                  hold_bt_d    = branch_taken_in;
               end else begin
                  en_d     = 1'b1;
                  pc_d     = pc_in;
                  instr_d  = instr_in;
                  gp_d     = tgt_gp_in;
                  sr_d     = tgt_sr_in;
                  result_d = result_in;
                  flags_d  = flags_in;
                  bt_d     = branch_taken_in;
               end
            end
         end

         MA_S_WAIT: begin
            if (mem_ready || timeout_hit) begin
               state_d   = MA_S_IDLE;
               mem_req_d = 1'b0;
               en_d      = 1'b1;
               pc_d      = hold_pc_q;
               instr_d   = hold_instr_q;
               gp_d      = hold_gp_q;
               sr_d      = hold_sr_q;
               bt_d      = hold_bt_q;
               if (mem_ready) begin
                  if (mem_we_q) begin
                     result_d = mem_addr_q;
                     flags_d  = hold_flags_q;
                  end else begin
                     result_d = mem_rdata;
                     flags_d  = load_flags(mem_rdata);
                  end
               end else begin
                  result_d = 24'd0;
                  flags_d  = 4'd0;
                  fault_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: state_d = MA_S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= MA_S_IDLE;
         cnt_q        <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 24'd0;
         mem_wdata_q  <= 24'd0;
         hold_pc_q    <= 24'd0;
         hold_instr_q <= 24'd0;
         hold_gp_q    <= 4'd0;
         hold_sr_q    <= 4'd0;
         hold_flags_q <= 4'd0;
         hold_bt_q    <= 1'b0;
         en_q         <= 1'b0;
         pc_q         <= 24'd0;
         instr_q      <= 24'd0;
         gp_q         <= 4'd0;
         sr_q         <= 4'd0;
         result_q     <= 24'd0;
         flags_q      <= 4'd0;
         bt_q         <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         hold_pc_q    <= hold_pc_d;
         hold_instr_q <= hold_instr_d;
         hold_gp_q    <= hold_gp_d;
         hold_sr_q    <= hold_sr_d;
         hold_flags_q <= hold_flags_d;
         hold_bt_q    <= hold_bt_d;
         en_q         <= en_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         gp_q         <= gp_d;
         sr_q         <= sr_d;
         result_q     <= result_d;
         flags_q      <= flags_d;
         bt_q         <= bt_d;
         fault_q      <= fault_d;
      end
   end

   assign stall_out        = (state_q == MA_S_WAIT);
   assign mem_req          = mem_req_q;
   assign mem_we           = mem_we_q;
   assign mem_addr         = mem_addr_q;
   assign mem_wdata        = mem_wdata_q;
   assign enable_out       = en_q;
   assign pc_out           = pc_q;
   assign instr_out        = instr_q;
   assign tgt_gp_out       = gp_q;
   assign tgt_sr_out       = sr_q;
   assign result_out       = result_q;
   assign flags_out        = flags_q;
   assign branch_taken_out = bt_q;
   assign fault_out        = fault_q;

endmodule

// File: tb/tb_stage4ma.sv
// -----------------------------------------------------------------------------
// tb_stage4ma
//   Directed bench for stage4ma (TIMEOUT_CYCLES=4). A transaction-level model
//   predicts retirements and the memory request; a compare process checks the
//   DUT against it every cycle, and each scenario adds hand-computed literals.
// -----------------------------------------------------------------------------
module tb_stage4ma;
   import stage4ma_pkg::*;

   localparam int TO = 4;
   localparam logic [7:0] OPC_ADD = 8'h01;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable_in = 1'b0;
   logic [23:0] pc_in = '0, instr_in = '0, result_in = '0, store_data_in = '0;
   logic [3:0]  tgt_gp_in = '0, tgt_sr_in = '0, flags_in = '0;
   logic        branch_taken_in = 1'b0;
   logic        stall_out, mem_req, mem_we;
   logic [23:0] mem_addr, mem_wdata;
   logic        mem_ready = 1'b0;
   logic [23:0] mem_rdata = '0;
   logic        enable_out, branch_taken_out, fault_out;
   logic [23:0] pc_out, instr_out, result_out;
   logic [3:0]  tgt_gp_out, tgt_sr_out, flags_out;

   always #5 clk = ~clk;

   stage4ma #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .pc_in(pc_in),
      .instr_in(instr_in), .tgt_gp_in(tgt_gp_in), .tgt_sr_in(tgt_sr_in),
      .result_in(result_in), .flags_in(flags_in), .store_data_in(store_data_in),
      .branch_taken_in(branch_taken_in), .stall_out(stall_out), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .enable_out(enable_out),
      .pc_out(pc_out), .instr_out(instr_out), .tgt_gp_out(tgt_gp_out),
      .tgt_sr_out(tgt_sr_out), .result_out(result_out), .flags_out(flags_out),
      .branch_taken_out(branch_taken_out), .fault_out(fault_out)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   typedef struct packed {
      logic [23:0] pc;
      logic [23:0] instr;
      logic [3:0]  gp;
      logic [3:0]  sr;
      logic [23:0] result;
      logic [3:0]  flags;
      logic        bt;
   } ret_t;

   ret_t        m_pend, m_ret;
   logic        m_busy = 1'b0, m_en = 1'b0, m_fault = 1'b0, m_we = 1'b0;
   logic [23:0] m_addr = '0, m_wdata = '0;
   int          m_waited = 0;

   always @(posedge clk or negedge rst_n) begin
      ret_t r;
      logic ld, st;
      if (!rst_n) begin
         m_busy   <= 1'b0;
         m_en     <= 1'b0;
         m_fault  <= 1'b0;
         m_waited <= 0;
      end else begin
         m_en <= 1'b0;
         if (m_busy) begin
            if (mem_ready) begin
               r = m_pend;
               if (m_we) r.result = m_addr;
               else begin
                  r.result = mem_rdata;
                  r.flags  = {2'b00, mem_rdata[23], (mem_rdata == 24'd0)};
               end
               m_ret  <= r;
               m_en   <= 1'b1;
               m_busy <= 1'b0;
            end else if (TO != 0 && m_waited + 1 == TO) begin
               r        = m_pend;
               r.result = '0;
               r.flags  = '0;
               m_ret   <= r;
               m_en    <= 1'b1;
               m_busy  <= 1'b0;
               m_fault <= 1'b1;
            end else begin
               m_waited <= m_waited + 1;
            end
         end else if (enable_in) begin
            r  = '{pc_in, instr_in, tgt_gp_in, tgt_sr_in, result_in, flags_in, branch_taken_in};
            ld = (instr_in[23:16] inside {OPC_R_LD, OPC_I_LDi});
            st = (instr_in[23:16] inside {OPC_R_ST, OPC_I_STi});
            if (ld || st) begin
               m_busy   <= 1'b1;
               m_waited <= 0;
               m_pend   <= r;
               m_we     <= st;
               m_addr   <= result_in;
               m_wdata  <= st ? store_data_in : 24'd0;
            end else begin
               m_ret <= r;
               m_en  <= 1'b1;
            end
         end
      end
   end

   // ---------------- per-cycle compare + retire log ----------------
   int          cyc = 0;
   logic [23:0] log_instr[$];
   int          log_cyc[$];

   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         chk("stall_out",  24'(stall_out),  24'(m_busy));
         chk("mem_req",    24'(mem_req),    24'(m_busy));
         chk("enable_out", 24'(enable_out), 24'(m_en));
         chk("fault_out",  24'(fault_out),  24'(m_fault));
         if (m_busy) begin
            chk("mem_we",    24'(mem_we), 24'(m_we));
            chk("mem_addr",  mem_addr,    m_addr);
            chk("mem_wdata", mem_wdata,   m_wdata);
         end
         if (m_en) begin
            chk("pc_out",     pc_out,               m_ret.pc);
            chk("instr_out",  instr_out,            m_ret.instr);
            chk("tgt_gp_out", 24'(tgt_gp_out),      24'(m_ret.gp));
            chk("tgt_sr_out", 24'(tgt_sr_out),      24'(m_ret.sr));
            chk("result_out", result_out,           m_ret.result);
            chk("flags_out",  24'(flags_out),       24'(m_ret.flags));
            chk("bt_out",     24'(branch_taken_out), 24'(m_ret.bt));
         end
         if (enable_out) begin
            log_instr.push_back(instr_out);
            log_cyc.push_back(cyc);
         end
      end
   end

   // ---------------- memory responder ----------------
   // Asserts mem_ready on the rdy_delay-th cycle of a request (0 = never);
   // idle_rdy drives spurious ready while no request is outstanding.
   int          rdy_delay = 1;
   logic [23:0] rd_val = '0;
   logic        idle_rdy = 1'b0;
   int          req_cnt = 0;

   always @(negedge clk) begin
      if (mem_req) begin
         req_cnt   = req_cnt + 1;
         mem_ready = (rdy_delay != 0) && (req_cnt == rdy_delay);
      end else begin
         req_cnt   = 0;
         mem_ready = idle_rdy;
      end
      mem_rdata = mem_ready ? rd_val : 24'h5A5A5A;
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [7:0] opc, input logic [23:0] pc,
                       input logic [23:0] res, input logic [23:0] sd,
                       input logic [3:0] fl, input logic hold);
      int n = 0;
      enable_in       = 1'b1;
      pc_in           = pc;
      instr_in        = {opc, pc[15:0]};
      tgt_gp_in       = pc[3:0];
      tgt_sr_in       = ~pc[3:0];
      result_in       = res;
      flags_in        = fl;
      store_data_in   = sd;
      branch_taken_in = pc[0];
      while (stall_out && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_bound", 24'(n < 50), 24'd1);
      @(negedge clk);
      if (!hold) enable_in = 1'b0;
   endtask

   task automatic count_req(output int n);
      n = 0;
      while (mem_req && n < 20) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int n;
      // reset state
      #1;
      chk("rst_mem_req", 24'(mem_req), 24'd0);
      chk("rst_stall",   24'(stall_out), 24'd0);
      chk("rst_enable",  24'(enable_out), 24'd0);
      chk("rst_fault",   24'(fault_out), 24'd0);
      chk("rst_result",  result_out, 24'd0);
      chk("rst_addr",    mem_addr, 24'd0);
      #11 rst_n = 1'b1;
      @(negedge clk);

      // ADD: one-cycle pass-through
      send(OPC_ADD, 24'h000200, 24'h000123, 24'h0, 4'h0, 1'b0);
      chk("add_en",     24'(enable_out), 24'd1);
      chk("add_result", result_out, 24'h000123);
      chk("add_req",    24'(mem_req), 24'd0);
      chk("add_stall",  24'(stall_out), 24'd0);
      idle(1);
      chk("add_pulse",  24'(enable_out), 24'd0);

      // LD, ready on 3rd wait cycle, negative data
      rdy_delay = 3; rd_val = 24'h800000;
      send(OPC_R_LD, 24'h000101, 24'h000040, 24'h005555, 4'hF, 1'b0);
      chk("ld_addr",  mem_addr, 24'h000040);
      chk("ld_we",    24'(mem_we), 24'd0);
      chk("ld_wdata", mem_wdata, 24'd0);
      chk("ld_stall", 24'(stall_out), 24'd1);
      count_req(n);
      chk("ld_req_cycles", 24'(n), 24'd3);
      chk("ld_en",     24'(enable_out), 24'd1);
      chk("ld_result", result_out, 24'h800000);
      chk("ld_flags",  24'(flags_out), 24'h2);
      chk("model_ld_result", m_ret.result, 24'h800000);
      idle(1);

      // ST, zero-wait memory
      rdy_delay = 1;
      send(OPC_I_STi, 24'h000300, 24'h000010, 24'h00ABCD, 4'h5, 1'b0);
      chk("st_we",    24'(mem_we), 24'd1);
      chk("st_wdata", mem_wdata, 24'h00ABCD);
      chk("st_addr",  mem_addr, 24'h000010);
      count_req(n);
      chk("st_req_cycles", 24'(n), 24'd1);
      chk("st_result", result_out, 24'h000010);
      chk("st_flags",  24'(flags_out), 24'h5);
      idle(1);

      // LD ready exactly on the last allowed wait cycle, zero data
      rdy_delay = TO; rd_val = 24'h000000;
      send(OPC_I_LDi, 24'h000402, 24'h000077, 24'h0, 4'hA, 1'b0);
      count_req(n);
      chk("ldb_req_cycles", 24'(n), 24'd4);
      chk("ldb_result", result_out, 24'h000000);
      chk("ldb_flags",  24'(flags_out), 24'h1);
      chk("ldb_fault",  24'(fault_out), 24'd0);
      chk("model_ldb_flags", 24'(m_ret.flags), 24'h1);
      idle(1);

      // Spurious mem_ready while idle is ignored, including at LD accept
      idle_rdy = 1'b1;
      idle(3);
      send(OPC_ADD, 24'h000503, 24'h000999, 24'h0, 4'h3, 1'b0);
      rdy_delay = 2; rd_val = 24'h012345;
      send(OPC_R_LD, 24'h000504, 24'h000080, 24'h0, 4'h0, 1'b0);
      count_req(n);
      chk("spur_req_cycles", 24'(n), 24'd2);
      chk("spur_result", result_out, 24'h012345);
      idle_rdy = 1'b0;
      idle(2);

      // Timeout: memory never answers
      rdy_delay = 0;
      send(OPC_R_LD, 24'h000605, 24'h0000F0, 24'h0, 4'h7, 1'b0);
      count_req(n);
      chk("to_req_cycles", 24'(n), 24'd4);
      chk("to_fault",  24'(fault_out), 24'd1);
      chk("to_en",     24'(enable_out), 24'd1);
      chk("to_result", result_out, 24'd0);
      idle(1);
      chk("to_pulse",  24'(enable_out), 24'd0);
      send(OPC_ADD, 24'h000606, 24'h000042, 24'h0, 4'h0, 1'b0);
      chk("to_sticky", 24'(fault_out), 24'd1);
      idle(1);

      // Async reset during a wait
      send(OPC_R_ST, 24'h000707, 24'h000020, 24'h000BEE, 4'h0, 1'b0);
      idle(1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req",   24'(mem_req), 24'd0);
      chk("arst_stall", 24'(stall_out), 24'd0);
      chk("arst_en",    24'(enable_out), 24'd0);
      chk("arst_fault", 24'(fault_out), 24'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      send(OPC_ADD, 24'h000808, 24'h000456, 24'h0, 4'h9, 1'b0);
      chk("arst_add_en",     24'(enable_out), 24'd1);
      chk("arst_add_result", result_out, 24'h000456);
      idle(1);

      // Back-to-back ADD, LD (zero-wait), ADD
      rdy_delay = 1; rd_val = 24'h000321;
      log_instr.delete();
      log_cyc.delete();
      send(OPC_ADD,  24'h000901, 24'h000011, 24'h0, 4'h0, 1'b1);
      send(OPC_R_LD, 24'h000902, 24'h000022, 24'h0, 4'h0, 1'b1);
      send(OPC_ADD,  24'h000903, 24'h000033, 24'h0, 4'h0, 1'b0);
      idle(3);
      chk("b2b_count", 24'(log_instr.size()), 24'd3);
      if (log_instr.size() == 3) begin
         chk("b2b_first",  log_instr[0], {OPC_ADD,  16'h0901});
         chk("b2b_second", log_instr[1], {OPC_R_LD, 16'h0902});
         chk("b2b_third",  log_instr[2], {OPC_ADD,  16'h0903});
         chk("b2b_gap",    24'(log_cyc[2] - log_cyc[1]), 24'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/stage4ma.md
Name: stage4ma

Overview:
- Memory-access pipeline stage. Sits between the EX/MA latch (execute outputs) and the WB stage.
- Consumes the execute result as address, store data and the decoded instruction.
- Issues single-beat load/store transactions on a req/ready data-memory port and stalls upstream while a transaction is outstanding.
- Forwards the completed instruction, with the loaded data as its result for loads, to write-back through its own MA/WB latch.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in S_WAIT before abort; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable_in  in  1  EX/MA latch holds a valid instruction
- pc_in  in  24  instruction PC
- instr_in  in  24  instruction word; [23:16] is set+opcode
- tgt_gp_in  in  4  target GP register
- tgt_sr_in  in  4  target special register
- result_in  in  24  ALU result / memory address
- flags_in  in  4  ALU flags
- store_data_in  in  24  store data
- branch_taken_in  in  1  branch resolved taken
- stall_out  out  1  upstream must hold its latches
- mem_req  out  1  data-memory request
- mem_we  out  1  1 = write
- mem_addr  out  24  word address
- mem_wdata  out  24  write data
- mem_ready  in  1  request accepted/completed this cycle
- mem_rdata  in  24  read data, valid when mem_ready and !mem_we
- enable_out  out  1  MA/WB latch valid (one cycle per retired instruction)
- pc_out, instr_out, tgt_gp_out, tgt_sr_out, result_out, flags_out, branch_taken_out  out  24/24/4/4/24/4/1  MA/WB latched copies
- fault_out  out  1  sticky memory-timeout fault

Behaviour:
- Reset (rst_n low, asynchronous): state=S_IDLE, counter=0, all outputs 0 (incl. mem_req, stall_out, enable_out, fault_out). A reset mid-transaction drops mem_req immediately; the pending instruction is discarded.
- Decode: is_ld = instr_in[23:16] in {OPC_R_LD, OPC_I_LDi}; is_st = {OPC_R_ST, OPC_I_STi}; is_mem = is_ld|is_st.
- S_IDLE, enable_in & !is_mem:
  - Latch all pass-through fields; result_out=result_in; flags_out=flags_in.
  - enable_out=1 next cycle; latency 1; back-to-back supported, no bubble.
- S_IDLE, enable_in & is_mem:
  - Register mem_addr=result_in, mem_we=is_st, mem_wdata=store_data_in (0 for loads).
  - Register instruction fields into holding regs; mem_req=1 from next cycle; go to S_WAIT; enable_out=0 next cycle.
- S_WAIT:
  - mem_req, mem_addr, mem_we, mem_wdata held stable; stall_out=1 (combinational: state==S_WAIT).
  - Counter increments each cycle without mem_ready.
  - On mem_ready: deassert mem_req next cycle; write holding regs to the MA/WB latch; enable_out=1 next cycle; go to S_IDLE.
    - Load: result_out=mem_rdata; flags_out Z=(mem_rdata==0), N=mem_rdata[23], C=V=0 (bit positions per flags.vh).
    - Store: result_out=address; flags_out=flags_in.
  - Minimum memory-op latency: 2 cycles (zero-wait memory).
- Timeout: counter==TIMEOUT_CYCLES without mem_ready (TIMEOUT_CYCLES≠0) → drop mem_req, fault_out=1 (sticky until reset), retire with result_out=0, enable_out=1, go to S_IDLE.
- mem_ready in S_IDLE (no request outstanding) is ignored.
- enable_in in S_WAIT is ignored; upstream holds it because of stall_out.
- The instruction is accepted on the same cycle stall_out drops.
- branch_taken is passed through only; the PC redirect is owned by the fetch stage.

Decomposition:
- Opcode and flag-index constants come from the shared iset.vh/opcodes.vh/flags.vh headers.
- Add MA state encodings (MA_S_IDLE, MA_S_WAIT) to a shared stage header.
- No sub-module required. An optional ma_decode (combinational is_ld/is_st) may be shared with hazard logic.

Test Plan:
- ADD retiring result 0x000123, flags 0x0 → one cycle later enable_out=1, result_out=0x000123, mem_req never high, stall_out=0.
- LD with result_in=0x000040, memory ready after 3 cycles returning 0x800000 → mem_req high 3 cycles with addr 0x000040, mem_we=0, stall_out high throughout; then result_out=0x800000, N=1, Z=0, enable_out pulse.
- ST with result_in=0x000010, store_data 0x00ABCD, ready on first wait cycle → mem_we=1, wdata 0x00ABCD, result_out=0x000010, total latency 2.
- TIMEOUT_CYCLES=4, mem_ready held low → mem_req drops after 4 wait cycles, fault_out=1 and stays 1, result_out=0, enable_out pulses once.
- rst_n pulled low during S_WAIT → mem_req, stall_out, enable_out go 0 without waiting for clk; after release, a following ADD retires normally.
- Back-to-back ADD, LD (ready after 1 cycle), ADD → the second ADD is held by stall_out and retires exactly one cycle after the LD; no instruction is lost or duplicated.
